affine_addr_gen_nd: RTL and testbench
=====================================

Name: affine_addr_gen_nd

Overview:
- Parametrised N-dimensional affine address generator; successor to the fixed 2-D scan address chain.
- Walks up to NDIM nested loop counters, innermost is dim 0. Emits one address per valid/ready handshake to the memory-port/unified-buffer read side.
- Adds start/done control, backpressure, a last flag, signed strides and a runtime-configurable extent per dimension.

Parameters:
- NDIM, 3, number of loop dimensions (1..8).
- CNT_W, 16, width of each extent and loop counter.
- ADDR_W, 16, address and offset width; all address arithmetic is modulo 2^ADDR_W.
- STRIDE_W, 16, width of each signed stride (two's complement); sign-extended or truncated to ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- extent  in  NDIM*CNT_W  per-dim trip count, dim k at bits [k*CNT_W +: CNT_W]; 0 is treated as 1.
- stride  in  NDIM*STRIDE_W  per-dim jump: delta applied when dim k is the highest dim that increments (all lower dims wrap).
- offset  in  ADDR_W  base address of the first element.
- addr_valid  out  1  addr holds a valid address.
- addr_ready  in  1  consumer accepts addr.
- addr  out  ADDR_W  current address.
- last  out  1  addr is the final address of the sweep; qualified by addr_valid.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset values (async, rst_n low): state IDLE, addr_valid 0, addr 0, last 0, busy 0, done 0, all counters 0.
- States:
  - IDLE: start=1 latches extent, stride and offset into internal registers. Clears counters, sets addr=offset, moves to RUN.
  - RUN: stays until the last address transfers.
- Latency:
  - start sampled at edge t gives addr_valid=1 and addr=offset after edge t.
  - Addresses after that are produced at one per cycle while addr_ready is held high.
- Handshake:
  - A transfer happens when addr_valid && addr_ready.
  - While addr_valid && !addr_ready, addr, last and the counters stay stable.
  - addr_valid never drops in RUN until the final transfer.
- Advance on each transfer. Let j be the lowest dim with cnt[j] != ext[j]-1.
  - cnt[i] becomes 0 for every i<j.
  - cnt[j] becomes cnt[j]+1.
  - addr becomes addr + sext(stride[j]).
  - No multipliers are used.
- Sweep end:
  - last = AND over all k of (cnt[k] == ext[k]-1).
  - A transfer with last=1 sets state IDLE, addr_valid 0, busy 0, and pulses done=1 for exactly one cycle.
  - addr keeps its final value.
- Total addresses emitted = product of effective extents. All extents 0 or 1 gives exactly one address (offset) with last=1.
- start while in RUN is ignored. start in the cycle done is high is legal: state is already IDLE, so the next sweep starts back-to-back.
- Config inputs may change freely during RUN; only the latched copies are used.
- Wrap-around: addr overflow and underflow wrap modulo 2^ADDR_W with no flag.
- Reset mid-sweep: immediate return to IDLE with the reset values above; no done pulse.

Test Plan:
- NDIM=2, extent={2,3} (dim1, dim0), stride0=1, stride1=8, offset=100, ready held 1 -> addr 100,101,102,110,111,112 on consecutive cycles; last only on 112; done one cycle later.
- NDIM=3, extents all 2, strides {5,3,1} (dim2..dim0), offset 0 -> 0,1,4,5,10,11,14,15; done pulses once.
- Backpressure: 2-D case above with addr_ready toggled 1,0,0,1,... -> same address sequence; addr and last stable across stall cycles; no address skipped or repeated.
- Wrap and sign: extent0=4, stride0=1, offset=16'hFFFE -> FFFE,FFFF,0000,0001. Then extent0=3, stride0=16'hFFFF, offset=5 -> 5,4,3.
- Degenerate and back-to-back: all extents 0 -> single addr=offset with last=1. start re-asserted in the done cycle -> next sweep's first addr_valid on the following cycle; start pulsed during RUN has no effect.
- Async reset: assert rst_n=0 mid-sweep between clock edges -> addr_valid, busy and done go 0 immediately. After release, the next start begins again at offset.

Source files
------------

// File: rtl/affine_addr_gen_nd.sv
// N-dimensional affine address generator: nested loop counters (dim 0 innermost)
// with signed per-dim strides, valid/ready output, last flag and start/done control.
module affine_addr_gen_nd #(
  parameter int unsigned NDIM     = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned STRIDE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NDIM*CNT_W-1:0]      extent,
  input  logic [NDIM*STRIDE_W-1:0]   stride,
  input  logic [ADDR_W-1:0]          offset,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [ADDR_W-1:0]          addr,
  output logic                       last,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CNT_W-1:0]  extm1_in [NDIM];
  logic [ADDR_W-1:0] stride_in [NDIM];
  logic [CNT_W-1:0]  extm1_q  [NDIM];
  logic [ADDR_W-1:0] stride_q [NDIM];
  logic [CNT_W-1:0]  cnt_q    [NDIM];
  logic [CNT_W-1:0]  cnt_n    [NDIM];
  logic [ADDR_W-1:0] delta;
  logic              last_n;
  logic              start_last;
  logic              carry;

  // Per-dim input decode: stored extents are (extent-1) with 0 treated as 1,
  // strides are sign-extended or truncated to the address width.
  for (genvar g = 0; g < NDIM; g++) begin : g_dim
    logic [CNT_W-1:0] ext_in;
    assign ext_in      = extent[g*CNT_W +: CNT_W];
    assign extm1_in[g] = (ext_in == '0) ? '0 : ext_in - CNT_W'(1);
    if (STRIDE_W >= ADDR_W) begin : g_trunc
      assign stride_in[g] = stride[g*STRIDE_W +: ADDR_W];
    end else begin : g_sext
      assign stride_in[g] = {{(ADDR_W-STRIDE_W){stride[g*STRIDE_W+STRIDE_W-1]}},
                             stride[g*STRIDE_W +: STRIDE_W]};
    end
  end

  always_comb begin
    start_last = 1'b1;
    for (int unsigned i = 0; i < NDIM; i++) begin
      if (extm1_in[i] != '0) start_last = 1'b0;
    end
  end

  // Ripple-carry over dims: wrap every saturated dim below the first
  // non-saturated one, bump that one and take its stride.
  always_comb begin
    carry  = 1'b1;
    delta  = '0;
    last_n = 1'b1;
    for (int unsigned i = 0; i < NDIM; i++) begin
      cnt_n[i] = cnt_q[i];
      if (carry) begin
        if (cnt_q[i] == extm1_q[i]) begin
          cnt_n[i] = '0;
        end else begin
          cnt_n[i] = cnt_q[i] + CNT_W'(1);
          delta    = stride_q[i];
          carry    = 1'b0;
        end
      end
      if (cnt_n[i] != extm1_q[i]) last_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_valid <= 1'b0;
      addr       <= '0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < NDIM; i++) begin
        cnt_q[i]    <= '0;
        extm1_q[i]  <= '0;
        stride_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NDIM; i++) begin
              cnt_q[i]    <= '0;
              extm1_q[i]  <= extm1_in[i];
              stride_q[i] <= stride_in[i];
            end
            addr       <= offset;
            last       <= start_last;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (addr_ready) begin
            if (last) begin
              state      <= IDLE;
              addr_valid <= 1'b0;
              busy       <= 1'b0;
              last       <= 1'b0;
              done       <= 1'b1;
            end else begin
              for (int unsigned i = 0; i < NDIM; i++) cnt_q[i] <= cnt_n[i];
              addr <= addr + delta;
              last <= last_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_addr_gen_nd.sv
// Scoreboard bench for affine_addr_gen_nd (NDIM=3, 16-bit): directed sweeps
// push expected addr/last; a negedge monitor checks every presented address.
module tb_affine_addr_gen_nd;

  localparam int NDIM = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NDIM*16-1:0] extent;
  logic [NDIM*16-1:0] stride;
  logic [15:0]       offset;
  logic              addr_valid;
  logic              addr_ready;
  logic [15:0]       addr;
  logic              last;
  logic              busy;
  logic              done;

  affine_addr_gen_nd #(.NDIM(NDIM), .CNT_W(16), .ADDR_W(16), .STRIDE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .extent(extent), .stride(stride),
    .offset(offset), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   pend_done = 1'b0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic l);
    q.push_back('{a: a, l: l});
  endtask

  // Ready pattern: mode 0 = always 1, mode 1 = repeating 1,0,0.
  initial begin
    int ph = 0;
    addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) addr_ready = 1'b1;
      else begin
        addr_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("done", {31'd0, done}, {31'd0, pend_done});
      pend_done = 1'b0;
      if (addr_valid) begin
        if (q.size() == 0) begin
          check("unexpected_addr", {16'd0, addr}, 32'hFFFF_FFFF);
        end else begin
          check("addr", {16'd0, addr}, {16'd0, q[0].a});
          check("last", {31'd0, last}, {31'd0, q[0].l});
          if (addr_ready) begin
            pend_done = q[0].l;
            void'(q.pop_front());
          end
        end
      end
    end else begin
      pend_done = 1'b0;
    end
  end

  function automatic logic [NDIM*16-1:0] pack3(input logic [15:0] d2, d1, d0);
    return {d2, d1, d0};
  endfunction

  // Drives start for one sampling edge, then checks one-cycle latency.
  task automatic do_start(input logic [NDIM*16-1:0] ext, input logic [NDIM*16-1:0] str,
                          input logic [15:0] off);
    extent = ext;
    stride = str;
    offset = off;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_valid", {31'd0, addr_valid}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_addr", {16'd0, addr}, {16'd0, off});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 300) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] v1 [6];
    logic [15:0] v2 [8];
    v1 = '{16'd100, 16'd101, 16'd102, 16'd110, 16'd111, 16'd112};
    v2 = '{16'd0, 16'd1, 16'd4, 16'd5, 16'd10, 16'd11, 16'd14, 16'd15};
    start  = 1'b0;
    extent = '0;
    stride = '0;
    offset = '0;
    rst_n  = 1'b0;
    #12;
    check("rst_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 2-D sweep, with start pulsed and config changed mid-run
    foreach (v1[i]) push(v1[i], i == 5);
    do_start(pack3(16'd1, 16'd2, 16'd3), pack3(16'd0, 16'd8, 16'd1), 16'd100);
    start  = 1'b1;
    offset = 16'd999;
    extent = pack3(16'd9, 16'd9, 16'd9);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t2d");
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);

    // 3-D sweep
    foreach (v2[i]) push(v2[i], i == 7);
    do_start(pack3(16'd2, 16'd2, 16'd2), pack3(16'd5, 16'd3, 16'd1), 16'd0);
    wait_done("t3d");
    @(negedge clk);

    // Backpressure on the 2-D case
    ready_mode = 1;
    foreach (v1[i]) push(v1[i], i == 5);
    do_start(pack3(16'd1, 16'd2, 16'd3), pack3(16'd0, 16'd8, 16'd1), 16'd100);
    wait_done("tbp");
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Overflow wrap, then negative stride
    push(16'hFFFE, 0); push(16'hFFFF, 0); push(16'h0000, 0); push(16'h0001, 1);
    do_start(pack3(16'd0, 16'd0, 16'd4), pack3(16'd0, 16'd0, 16'd1), 16'hFFFE);
    wait_done("twrap");
    push(16'd5, 0); push(16'd4, 0); push(16'd3, 1);
    // start asserted during the done cycle: back-to-back sweep
    do_start(pack3(16'd0, 16'd0, 16'd3), pack3(16'd0, 16'd0, 16'hFFFF), 16'd5);
    wait_done("tneg");

    // Degenerate extents, back-to-back
    push(16'h1234, 1);
    do_start(pack3(16'd0, 16'd0, 16'd0), pack3(16'd7, 16'd7, 16'd7), 16'h1234);
    wait_done("tdeg");
    check("final_addr_held", {16'd0, addr}, 32'h1234);
    @(negedge clk);

    // Async reset mid-sweep
    mon_en = 1'b0;
    q.delete();
    do_start(pack3(16'd4, 16'd4, 16'd4), pack3(16'd1, 16'd1, 16'd1), 16'd50);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, addr_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_addr", {16'd0, addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    push(16'd7, 0); push(16'd9, 1);
    do_start(pack3(16'd1, 16'd1, 16'd2), pack3(16'd0, 16'd0, 16'd2), 16'd7);
    wait_done("tpost");
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
